// File: rtl/oled_frame_ctrl.sv
// OLED 8-bit parallel bus owner: forwards the init sequencer's bus until init is done,
// then on request streams a window/write-RAM header followed by the whole framebuffer.
module oled_frame_ctrl #(
  parameter int WIDTH      = 96,
  parameter int HEIGHT     = 64,
  parameter int BPP        = 2,
  parameter int ADDR_WIDTH = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  init_done,
  input  logic                  init_cs,
  input  logic                  init_e,
  input  logic                  init_dc,
  input  logic [7:0]            init_dout,
  input  logic                  start,
  output logic                  busy,
  output logic                  frame_done,
  output logic [ADDR_WIDTH-1:0] fb_addr,
  input  logic [7:0]            fb_data,
  output logic                  oled_cs,
  output logic                  oled_e,
  output logic                  oled_dc,
  output logic [7:0]            oled_dout
);

  // state     | meaning
  // WAIT_INIT | init sequencer owns the bus, its signals are registered through
  // IDLE      | bus deselected, waiting for start or a pending request
  // HDR       | sending the 7-byte window/write-RAM command header
  // DATA      | streaming framebuffer bytes from VRAM
  // FINISH    | one deselected cycle, frame_done pulse

  localparam int N  = WIDTH * HEIGHT * BPP;
  localparam int CW = (ADDR_WIDTH > 3) ? ADDR_WIDTH : 3;
  localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);
  localparam logic [CW-1:0] HDR_LAST = CW'(6);
  localparam logic [7:0] COL_END = 8'(WIDTH - 1);
  localparam logic [7:0] ROW_END = 8'(HEIGHT - 1);

  typedef enum logic [2:0] {
    WAIT_INIT,
    IDLE,
    HDR,
    DATA,
    FINISH
  } state_t;

  state_t                state, state_n;
  logic [CW-1:0]         idx, idx_n;
  logic                  phase, phase_n;
  logic                  pending, pending_n;
  logic [ADDR_WIDTH-1:0] fb_addr_q, fb_addr_n;
  logic [7:0]            dout_hold, dout_hold_n;
  logic                  init_cs_q, init_e_q, init_dc_q;
  logic [7:0]            init_dout_q;
  logic [7:0]            hdr_byte;
  logic                  hdr_dc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= WAIT_INIT;
      idx         <= '0;
      phase       <= 1'b0;
      pending     <= 1'b0;
      fb_addr_q   <= '0;
      dout_hold   <= 8'h00;
      init_cs_q   <= 1'b1;
      init_e_q    <= 1'b1;
      init_dc_q   <= 1'b0;
      init_dout_q <= 8'h00;
    end else begin
      state     <= state_n;
      idx       <= idx_n;
      phase     <= phase_n;
      pending   <= pending_n;
      fb_addr_q <= fb_addr_n;
      dout_hold <= dout_hold_n;
      if (state == WAIT_INIT) begin
        init_cs_q   <= init_cs;
        init_e_q    <= init_e;
        init_dc_q   <= init_dc;
        init_dout_q <= init_dout;
      end
    end
  end

  always_comb begin
    hdr_byte = 8'h00;
    hdr_dc   = 1'b1;
    case (idx[2:0])
      3'd0:    begin hdr_byte = 8'h15;   hdr_dc = 1'b0; end
      3'd1:    begin hdr_byte = 8'h00;   hdr_dc = 1'b1; end
      3'd2:    begin hdr_byte = COL_END; hdr_dc = 1'b1; end
      3'd3:    begin hdr_byte = 8'h75;   hdr_dc = 1'b0; end
      3'd4:    begin hdr_byte = 8'h00;   hdr_dc = 1'b1; end
      3'd5:    begin hdr_byte = ROW_END; hdr_dc = 1'b1; end
      3'd6:    begin hdr_byte = 8'h5C;   hdr_dc = 1'b0; end
      default: begin hdr_byte = 8'h00;   hdr_dc = 1'b1; end
    endcase
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    phase_n     = phase;
    pending_n   = pending | start;
    fb_addr_n   = fb_addr_q;
    dout_hold_n = dout_hold;
    busy        = 1'b0;
    frame_done  = 1'b0;
    oled_cs     = 1'b1;
    oled_e      = 1'b1;
    oled_dc     = 1'b0;
    oled_dout   = 8'h00;

    case (state)
      WAIT_INIT: begin
        oled_cs   = init_cs_q;
        oled_e    = init_e_q;
        oled_dc   = init_dc_q;
        oled_dout = init_dout_q;
        if (init_done) state_n = IDLE;
      end
      IDLE: begin
        pending_n = 1'b0;
        if (start || pending) begin
          state_n = HDR;
          idx_n   = '0;
          phase_n = 1'b0;
        end
      end
      HDR: begin
        busy      = 1'b1;
        oled_cs   = 1'b0;
        oled_e    = ~phase;
        oled_dc   = hdr_dc;
        oled_dout = hdr_byte;
        phase_n   = ~phase;
        // VRAM address for data byte 0 goes out during the last header byte's phase 1
        if (!phase && idx == HDR_LAST) fb_addr_n = '0;
        if (phase) begin
          if (idx == HDR_LAST) begin
            state_n = DATA;
            idx_n   = '0;
          end else begin
            idx_n = idx + CW'(1);
          end
        end
      end
      DATA: begin
        busy      = 1'b1;
        oled_cs   = 1'b0;
        oled_e    = ~phase;
        oled_dc   = 1'b1;
        oled_dout = phase ? dout_hold : fb_data;
        phase_n   = ~phase;
        if (!phase) begin
          dout_hold_n = fb_data;
          if (idx != LAST_IDX) fb_addr_n = fb_addr_q + ADDR_WIDTH'(1);
        end else if (idx == LAST_IDX) begin
          state_n = FINISH;
        end else begin
          idx_n = idx + CW'(1);
        end
      end
      FINISH: begin
        frame_done = 1'b1;
        pending_n  = start;
        if (pending) begin
          state_n = HDR;
          idx_n   = '0;
          phase_n = 1'b0;
        end else begin
          state_n = IDLE;
        end
      end
      default: state_n = WAIT_INIT;
    endcase
  end

  assign fb_addr = fb_addr_q;

endmodule

// File: tb/tb_oled_frame_ctrl.sv
// Self-checking bench for oled_frame_ctrl: frame-position reference model checked every
// cycle, directed timing checks, then randomized start/init/reset traffic.
module tb_oled_frame_ctrl;

  localparam int W  = 2;
  localparam int H  = 2;
  localparam int B  = 2;
  localparam int AW = 3;
  localparam int N  = W * H * B;
  localparam int FL = 2 * (7 + N);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done = 1'b0;
  logic          init_cs = 1'b1, init_e = 1'b1, init_dc = 1'b0;
  logic [7:0]    init_dout = 8'h00;
  logic          start = 1'b0;
  logic          busy, frame_done;
  logic [AW-1:0] fb_addr;
  logic [7:0]    fb_data = 8'h00;
  logic          oled_cs, oled_e, oled_dc;
  logic [7:0]    oled_dout;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  oled_frame_ctrl #(.WIDTH(W), .HEIGHT(H), .BPP(B), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .init_done(init_done),
    .init_cs(init_cs), .init_e(init_e), .init_dc(init_dc), .init_dout(init_dout),
    .start(start), .busy(busy), .frame_done(frame_done),
    .fb_addr(fb_addr), .fb_data(fb_data),
    .oled_cs(oled_cs), .oled_e(oled_e), .oled_dc(oled_dc), .oled_dout(oled_dout)
  );

  always #5 clk = ~clk;

  // synchronous-read VRAM whose contents are 0xA0 + address
  always @(posedge clk) fb_data <= 8'hA0 + 8'(fb_addr);

  logic [7:0] hdr [7];
  logic       hdr_dc [7];
  initial begin
    hdr[0] = 8'h15; hdr[1] = 8'h00; hdr[2] = 8'(W - 1); hdr[3] = 8'h75;
    hdr[4] = 8'h00; hdr[5] = 8'(H - 1); hdr[6] = 8'h5C;
    hdr_dc[0] = 1'b0; hdr_dc[1] = 1'b1; hdr_dc[2] = 1'b1; hdr_dc[3] = 1'b0;
    hdr_dc[4] = 1'b1; hdr_dc[5] = 1'b1; hdr_dc[6] = 1'b0;
  end

  // model: in init, otherwise position within the current frame (-1 when none)
  bit         m_init = 1'b1;
  int         m_pos = -1;
  bit         m_fin = 1'b0;
  bit         m_pend = 1'b0;
  int         m_fa = 0;
  logic       mq_cs = 1'b1, mq_e = 1'b1, mq_dc = 1'b0;
  logic [7:0] mq_dout = 8'h00;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      m_init = 1'b1; m_pos = -1; m_fin = 1'b0; m_pend = 1'b0; m_fa = 0;
      mq_cs = 1'b1; mq_e = 1'b1; mq_dc = 1'b0; mq_dout = 8'h00;
    end else if (m_init) begin
      mq_cs = init_cs; mq_e = init_e; mq_dc = init_dc; mq_dout = init_dout;
      if (start) m_pend = 1'b1;
      if (init_done) m_init = 1'b0;
    end else if (m_pos >= 0) begin
      if (start) m_pend = 1'b1;
      m_pos++;
      if (m_pos == FL) begin
        m_pos = -1;
        m_fin = 1'b1;
      end else if (m_pos >= 13) begin
        m_fa = ((m_pos - 13) / 2 < N - 1) ? (m_pos - 13) / 2 : N - 1;
      end
    end else if (m_fin) begin
      m_fin = 1'b0;
      if (m_pend) m_pos = 0;
      m_pend = start;
    end else if (start || m_pend) begin
      m_pos = 0;
      m_pend = 1'b0;
    end
  end

  always @(negedge clk) begin
    logic       e_cs, e_e, e_dc, e_busy, e_fd;
    logic [7:0] e_dout;
    logic [15:0] got, exp;
    int b;
    e_cs = 1'b1; e_e = 1'b1; e_dc = 1'b0; e_dout = 8'h00; e_busy = 1'b0; e_fd = 1'b0;
    if (m_init) begin
      e_cs = mq_cs; e_e = mq_e; e_dc = mq_dc; e_dout = mq_dout;
    end else if (m_pos >= 0) begin
      b = m_pos / 2;
      e_cs = 1'b0;
      e_e = (m_pos % 2 == 0);
      e_busy = 1'b1;
      if (b < 7) begin
        e_dc = hdr_dc[b]; e_dout = hdr[b];
      end else begin
        e_dc = 1'b1; e_dout = 8'hA0 + 8'(b - 7);
      end
    end else begin
      e_fd = m_fin;
    end
    got = {oled_cs, oled_e, oled_dc, oled_dout, busy, frame_done, fb_addr};
    exp = {e_cs, e_e, e_dc, e_dout, e_busy, e_fd, 3'(m_fa)};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL model_cycle cyc=%0d got cs/e/dc/dout/busy/fd/addr=%h required=%h",
               cyc, got, exp);
    end
  end

  task automatic lit(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h required=%h", name, cyc, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) tick();
  endtask

  int i_cyc, h, h2;

  initial begin
    tick(); tick();
    rst = 1'b0;

    init_dout = 8'hAE; init_dc = 1'b0;
    for (int k = 0; k < 6; k++) begin
      init_e = ~init_e;
      tick();
    end
    init_e = 1'b0;
    tick();
    lit("passthru_e", 32'(oled_e), 32'd0);
    lit("passthru_dout", 32'(oled_dout), 32'hAE);

    start = 1'b1; tick(); start = 1'b0;
    tick();
    lit("no_start_in_init", 32'(busy), 32'd0);

    init_done = 1'b1; i_cyc = cyc; tick(); init_done = 1'b0;
    lit("idle_after_init", 32'({oled_cs, oled_e}), 32'b11);
    tick();
    lit("hdr_at_i_plus_2", 32'(cyc - i_cyc), 32'd2);
    lit("hdr_byte0", 32'({oled_cs, oled_dout}), 32'h015);
    h = cyc;

    goto(h + 4);
    start = 1'b1; tick(); start = 1'b0;
    goto(h + 13); lit("fb_addr0", 32'(fb_addr), 32'd0);
    goto(h + 14); lit("data0", 32'(oled_dout), 32'hA0);
    goto(h + 29); lit("data7_hold", 32'({oled_e, oled_dout}), 32'h0A7);
    goto(h + 30); lit("frame_done1", 32'({frame_done, busy, oled_cs}), 32'b101);
    goto(h + 31); lit("hdr2_start", 32'({oled_cs, oled_dout}), 32'h015);
    goto(h + 61); lit("frame_done2", 32'(frame_done), 32'd1);
    goto(h + 62); lit("idle_after2", 32'({busy, oled_cs}), 32'b01);

    start = 1'b1; tick(); start = 1'b0;
    h2 = cyc;
    goto(h2 + 20);
    #2 rst = 1'b1;
    #1 lit("rst_async", 32'({oled_cs, oled_e, oled_dc, oled_dout, fb_addr, busy, frame_done}),
           32'({1'b1, 1'b1, 1'b0, 8'h00, 3'd0, 1'b0, 1'b0}));
    tick(); tick();
    rst = 1'b0;
    for (int k = 0; k < 30; k++) tick();
    lit("no_frame_before_init", 32'(busy), 32'd0);

    for (int k = 0; k < 4000; k++) begin
      start     = ($urandom_range(0, 9) == 0);
      init_cs   = 1'($urandom);
      init_e    = 1'($urandom);
      init_dc   = 1'($urandom);
      init_dout = 8'($urandom);
      init_done = ($urandom_range(0, 29) == 0);
      if ($urandom_range(0, 599) == 0) begin
        rst = 1'b1;
        tick();
        rst = 1'b0;
      end
      tick();
    end
    start = 1'b0; init_done = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
